dither_bit_packer: RTL and testbench

Downstream neighbour of the dither stage: consumes the 1-bit dithered pixel stream (pixel, hcount, vcount, valid) and packs it into WORD_W-bit words with linear frame-buffer addresses for the BRAM/GIF-encoder write port. Frame and row alignment come from the incoming counts. A 2-entry output queue with valid/ready absorbs short write-side stalls. Overflow is flagged and never blocks the dither pipeline.

---
 rtl/dither_pkg.sv | 21 ++
 rtl/dither_word_fifo.sv | 61 ++++++
 rtl/dither_bit_packer.sv | 166 ++++++++++++++++
 tb/tb_dither_bit_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// dither_pkg: definitions shared by the dither pipeline back end.
//   HCOUNT_W / VCOUNT_W : widths of the pixel column / row counters
//   pack_state_t        : bit packer states (IDLE waits for a frame start,
//                         PACK is normal operation)
//   words_per_row()     : number of WORD_W-pixel words needed to hold
//                         'width' pixels, rounding a partial word up
package dither_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PACK = 1'b1
    } pack_state_t;

    function automatic int words_per_row(input int width, input int word_w);
        return (width + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/dither_word_fifo.sv
// dither_word_fifo: 2-entry valid/ready FIFO used as the output queue of the
// bit packer. The head entry is read straight from a register, so a word
// pushed on one cycle is presented on the next and held while out_ready=0.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the pushed data is discarded (the caller flags that).
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid, in_data  : write side
//   out_valid, out_data: head entry
//   out_ready          : consumer takes the head entry this cycle
//   full               : both entries occupied
module dither_word_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              full
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // When full, the slot being popped is the one the write pointer points at.
    assign push      = in_valid && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dither_bit_packer.sv
// dither_bit_packer: packs the 1-bit dithered pixel stream into WORD_W-bit
// words (first pixel in the MSB) with linear frame-buffer word addresses and
// hands them to a 2-entry output queue with valid/ready. The dither pipeline
// is never stalled: a word that meets a full queue is dropped and the sticky
// overflow flag is raised until the next frame start.
//
// Ports:
//   clk_in, rst_n_in      : clock, asynchronous active-low reset
//   dithered_valid/pixel  : pixel strobe and value from the dither stage
//   dithered_hcount/vcount: pixel column / row
//   wr_valid, wr_ready    : output word handshake
//   wr_addr, wr_data      : word address and packed pixels
//   frame_done            : one-cycle pulse with the last word of a frame
//   overflow              : sticky, a completed word was dropped
//
// Build option DITHER_PACK_ROW_PAD_EN: when defined, every row starts on a
// word boundary and a partial word at row end is zero-padded and enqueued.
// When undefined, words run across row boundaries.
module dither_bit_packer
    import dither_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int WORD_W       = 8,
    parameter int ADDR_W       = 14
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                dithered_valid,
    input  logic                dithered_pixel,
    input  logic [HCOUNT_W-1:0] dithered_hcount,
    input  logic [VCOUNT_W-1:0] dithered_vcount,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WORD_W-1:0]   wr_data,
    output logic                frame_done,
    output logic                overflow
);

    localparam int                  BIDX_W   = $clog2(WORD_W);
    localparam logic [BIDX_W-1:0]   LAST_IDX = BIDX_W'(WORD_W - 1);
    localparam logic [HCOUNT_W-1:0] WIDTH_H  = HCOUNT_W'(FRAME_WIDTH);
    localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(FRAME_WIDTH - 1);
    localparam logic [VCOUNT_W-1:0] HEIGHT_V = VCOUNT_W'(FRAME_HEIGHT);
    localparam logic [VCOUNT_W-1:0] LAST_ROW = VCOUNT_W'(FRAME_HEIGHT - 1);
    localparam logic [WORD_W-1:0]   MSB_ONE  = {1'b1, {(WORD_W - 1){1'b0}}};
`ifdef DITHER_PACK_ROW_PAD_EN
    localparam int FRAME_WORDS = words_per_row(FRAME_WIDTH, WORD_W) * FRAME_HEIGHT;
`else
    // Without padding the frame is one long run of pixels.
    localparam int FRAME_WORDS = words_per_row(FRAME_WIDTH * FRAME_HEIGHT, WORD_W);
`endif

    generate
        if (WORD_W < 2 || WORD_W > 32 || (WORD_W & (WORD_W - 1)) != 0) begin : g_bad_word_w
            $error("dither_bit_packer: WORD_W must be a power of two in 2..32");
        end
        if (FRAME_WORDS > (1 << ADDR_W)) begin : g_addr_too_narrow
            $error("dither_bit_packer: ADDR_W cannot address one frame of words");
        end
`ifndef DITHER_PACK_ROW_PAD_EN
        if (((FRAME_WIDTH * FRAME_HEIGHT) % WORD_W) != 0) begin : g_bad_geometry
            $error("dither_bit_packer: frame pixel count must be a multiple of WORD_W");
        end
`endif
    endgenerate

    pack_state_t         state;
    logic [BIDX_W-1:0]   bit_idx;
    logic [BIDX_W-1:0]   eff_idx;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   eff_shreg;
    logic [WORD_W-1:0]   packed_word;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   eff_addr;
    logic                accept;
    logic                frame_start;
    logic                realign;
    logic                row_end;
    logic                frame_end;
    logic                packing;
    logic                word_done;
    logic                queue_full;
    logic                drop;
    logic [ADDR_W+WORD_W-1:0] queue_out;

    assign accept      = dithered_valid && (dithered_hcount < WIDTH_H) &&
                         (dithered_vcount < HEIGHT_V);
    assign frame_start = accept && (dithered_hcount == '0) && (dithered_vcount == '0);
    assign row_end     = (dithered_hcount == LAST_COL);
    assign frame_end   = row_end && (dithered_vcount == LAST_ROW);
    // A frame start is honoured from any state, including mid-frame.
    assign packing     = accept && ((state == PACK) || frame_start);

`ifdef DITHER_PACK_ROW_PAD_EN
    // Every row begins a fresh word; any stray partial word is abandoned.
    assign realign   = accept && (dithered_hcount == '0);
    assign word_done = packing && ((eff_idx == LAST_IDX) || row_end);
`else
    assign realign   = frame_start;
    assign word_done = packing && (eff_idx == LAST_IDX);
`endif

    // Bit index, partial word and address as seen by the current pixel,
    // after any frame-start or row realignment has been applied.
    assign eff_idx     = realign ? '0 : bit_idx;
    assign eff_shreg   = realign ? '0 : shreg;
    assign eff_addr    = frame_start ? '0 : addr;
    assign packed_word = eff_shreg | (dithered_pixel ? (MSB_ONE >> eff_idx) : '0);

    // The queue head is occupied whenever it is full, so a pop happens
    // exactly when the consumer is ready.
    assign drop = word_done && queue_full && !wr_ready;

    // Packer state: bit position, partial word, word address, frame
    // tracking and the two registered status outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            addr       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (packing) begin
                if (word_done) begin
                    bit_idx <= '0;
                    shreg   <= '0;
                    // A dropped word still consumes its address slot.
                    addr    <= eff_addr + ADDR_W'(1);
                end else begin
                    bit_idx <= eff_idx + BIDX_W'(1);
                    shreg   <= packed_word;
                    addr    <= eff_addr;
                end
                overflow <= drop || (overflow && !frame_start);
                if (frame_end) begin
                    state      <= IDLE;
                    frame_done <= word_done;
                end else begin
                    state <= PACK;
                end
            end
        end
    end

    dither_word_fifo #(
        .DATA_W (ADDR_W + WORD_W)
    ) u_queue (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .in_valid  (word_done),
        .in_data   ({eff_addr, packed_word}),
        .out_valid (wr_valid),
        .out_data  (queue_out),
        .out_ready (wr_ready),
        .full      (queue_full)
    );

    assign wr_addr = queue_out[ADDR_W+WORD_W-1 -: ADDR_W];
    assign wr_data = queue_out[WORD_W-1:0];

endmodule

// File: tb/tb_dither_bit_packer.sv
// tb_dither_bit_packer: randomized bench for dither_bit_packer on a small
// 20x6 frame with 8-pixel words. The reference model places each pixel by
// its linear position in the frame (or its position in the row when row
// padding is built in), and models the 2-entry queue as the scoreboard
// queue itself. A monitor on the falling edge pops and compares every word
// the DUT hands over and checks wr_valid, frame_done and overflow each cycle.
module tb_dither_bit_packer;
    import dither_pkg::*;

    localparam int FW  = 20;
    localparam int FH  = 6;
    localparam int W   = 8;
    localparam int AW  = 8;
    localparam int WPR = (FW + W - 1) / W;
`ifdef DITHER_PACK_ROW_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic                clk_in = 1'b0;
    logic                rst_n_in = 1'b1;
    logic                dithered_valid = 1'b0;
    logic                dithered_pixel = 1'b0;
    logic [HCOUNT_W-1:0] dithered_hcount = '0;
    logic [VCOUNT_W-1:0] dithered_vcount = '0;
    logic                wr_valid;
    logic                wr_ready = 1'b0;
    logic [AW-1:0]       wr_addr;
    logic [W-1:0]        wr_data;
    logic                frame_done;
    logic                overflow;

    dither_bit_packer #(
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .WORD_W       (W),
        .ADDR_W       (AW)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .dithered_valid  (dithered_valid),
        .dithered_pixel  (dithered_pixel),
        .dithered_hcount (dithered_hcount),
        .dithered_vcount (dithered_vcount),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .overflow        (overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } word_t;

    word_t      exp_q[$];
    word_t      mon_word;
    int         compared = 0;
    int         mismatched = 0;
    int         fd_count = 0;
    bit         fd_pend = 1'b0;
    bit         fd_cur = 1'b0;
    bit         ov_pend = 1'b0;
    bit         ov_cur = 1'b0;
    bit         pushed_now = 1'b0;
    bit         active = 1'b0;
    bit         model_ovf = 1'b0;
    logic [W-1:0] acc = '0;
    logic [7:0] pat_bits = 8'hB1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        check_output({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_output({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check_output({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_output({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // True when the pixel at (h, vc) is the last one placed in its word.
    function automatic bit word_ends(input int h, input int vc);
        if (PAD) return ((h % W) == W - 1) || (h == FW - 1);
        return (((vc * FW) + h) % W) == W - 1;
    endfunction

    // Drives one cycle and advances the reference model. rdy_mode:
    // 0 = ready low, 1 = ready high, 2 = ready only when a word completes
    // into a full queue (exercises simultaneous push and pop).
    task automatic apply_stimulus(input bit v, input bit p, input int h, input int vc, input int rdy_mode);
        bit accepted;
        bit rdy;
        int word_addr;
        int pos;
        @(posedge clk_in);
        #1;
        fd_cur     = fd_pend;
        ov_cur     = ov_pend;
        pushed_now = 1'b0;
        fd_pend    = 1'b0;
        accepted   = v && (h < FW) && (vc < FH);
        if (rdy_mode == 2) rdy = accepted && word_ends(h, vc) && (exp_q.size() == 2);
        else rdy = (rdy_mode != 0);
        dithered_valid  = v;
        dithered_pixel  = p;
        dithered_hcount = HCOUNT_W'(h);
        dithered_vcount = VCOUNT_W'(vc);
        wr_ready        = rdy;
        if (accepted && h == 0 && vc == 0) begin
            active    = 1'b1;
            model_ovf = 1'b0;
            acc       = '0;
        end
        if (accepted && active) begin
            if (PAD) begin
                word_addr = vc * WPR + h / W;
                pos       = W - 1 - (h % W);
            end else begin
                word_addr = (vc * FW + h) / W;
                pos       = W - 1 - ((vc * FW + h) % W);
            end
            if (p) acc[pos] = 1'b1;
            if (word_ends(h, vc)) begin
                if (exp_q.size() == 2 && !rdy) begin
                    model_ovf = 1'b1;
                end else begin
                    exp_q.push_back(word_t'{addr: AW'(word_addr), data: acc});
                    pushed_now = 1'b1;
                end
                acc = '0;
                if (h == FW - 1 && vc == FH - 1) fd_pend = 1'b1;
            end
            if (h == FW - 1 && vc == FH - 1) active = 1'b0;
        end
        ov_pend = model_ovf;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        rst_n_in       = 1'b0;
        dithered_valid = 1'b0;
        wr_ready       = 1'b0;
        exp_q.delete();
        fd_pend    = 1'b0;
        fd_cur     = 1'b0;
        ov_pend    = 1'b0;
        ov_cur     = 1'b0;
        pushed_now = 1'b0;
        active     = 1'b0;
        model_ovf  = 1'b0;
        acc        = '0;
        #1;
        check_reset_outputs("midframe_reset");
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 0, 0, 1);
    endtask

    // One frame of pixels. policy 0: random gaps, out-of-range junk and
    // random ready; 1: ready low for 40 pixels mid-frame; 2: queue kept full.
    task automatic run_frame(input int policy, input bit pattern, input int reset_at);
        int idx;
        bit p;
        idx = 0;
        for (int vc = 0; vc < FH; vc++) begin
            for (int h = 0; h < FW; h++) begin
                p = (pattern && idx < 8) ? pat_bits[7 - idx] : 1'($urandom_range(0, 1));
                if (policy == 0) begin
                    while ($urandom_range(0, 9) == 0) begin
                        case ($urandom_range(0, 2))
                            0: apply_stimulus(1'b0, 1'($urandom_range(0, 1)), h, vc, int'($urandom_range(0, 1)));
                            1: apply_stimulus(1'b1, 1'($urandom_range(0, 1)), FW + int'($urandom_range(0, 30)), vc, 1);
                            default: apply_stimulus(1'b1, 1'($urandom_range(0, 1)), h, FH + int'($urandom_range(0, 20)), 1);
                        endcase
                    end
                    apply_stimulus(1'b1, p, h, vc, ($urandom_range(0, 3) != 0) ? 1 : 0);
                end else if (policy == 1) begin
                    apply_stimulus(1'b1, p, h, vc, (idx >= 30 && idx < 70) ? 0 : 1);
                end else begin
                    apply_stimulus(1'b1, p, h, vc, 2);
                end
                if (pattern && idx == 7) begin
                    apply_stimulus(1'b0, 1'b0, 0, 0, 1);
                    @(negedge clk_in);
                    check_output("b1_wr_valid", 32'(wr_valid), 32'd1);
                    check_output("b1_wr_addr", 32'(wr_addr), 32'd0);
                    check_output("b1_wr_data", 32'(wr_data), 32'hB1);
                end
                if (idx == reset_at) pulse_reset();
                idx++;
            end
        end
    endtask

    // Monitor: per-cycle status checks and scoreboard pops on handshakes.
    always @(negedge clk_in) begin
        check_output("frame_done", 32'(frame_done), 32'(fd_cur));
        check_output("overflow", 32'(overflow), 32'(ov_cur));
        check_output("wr_valid", 32'(wr_valid), 32'((exp_q.size() - int'(pushed_now)) > 0));
        if (frame_done) fd_count++;
        if (wr_valid && wr_ready && (exp_q.size() - int'(pushed_now)) > 0) begin
            mon_word = exp_q.pop_front();
            check_output("wr_addr", 32'(wr_addr), 32'(mon_word.addr));
            check_output("wr_data", 32'(wr_data), 32'(mon_word.data));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        idle_cycles(3);

        $display("[TB] frame 1: directed first word, random gaps and ready");
        run_frame(0, 1'b1, -1);
        idle_cycles(6);

        $display("[TB] frame 2: 40-cycle write stall");
        run_frame(1, 1'b0, -1);
        idle_cycles(6);

        $display("[TB] frame 3: queue held full with push and pop together");
        run_frame(2, 1'b0, -1);
        idle_cycles(6);

        $display("[TB] frame 4: reset mid-frame");
        run_frame(0, 1'b0, 50);
        idle_cycles(4);

        $display("[TB] frame 5: restart after reset");
        run_frame(0, 1'b0, -1);
        idle_cycles(10);

        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        check_output("frame_done_pulses", 32'(fd_count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
